instruction_fetcher: RTL and testbench

Front-end fetch stage sitting directly upstream of the reorder buffer. It issues word reads to the memory controller and buffers returned instructions in a small in-order queue. It launches one instruction per slot into the ROB (`if_ins_launch_flag` / `if_ins` / `if_ins_pc`), honouring `rob_full`. It redirects on JAL, stalls on JALR until the target is resolved, and restarts from a corrected PC on `rob_flush`.

---
 rtl/instruction_fetcher.sv | 147 ++++++++++++++
 tb/tb_instruction_fetcher.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// Fetch stage: issues word reads, queues returned instructions in order and
// launches at most one every other cycle into the ROB. Handles JAL, JALR stalls and flushes.
module instruction_fetcher #(
    parameter int unsigned IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    input  logic        rob_full,
    output logic        if_ins_launch_flag,
    output logic [31:0] if_ins,
    output logic [31:0] if_ins_pc,
    input  logic        rob_flush,
    input  logic [31:0] flush_pc,
    input  logic        jalr_resolve,
    input  logic [31:0] jalr_target
);
    localparam int AW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int CW = $clog2(IQ_DEPTH) + 1;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, STALL_JALR} state_t;

    state_t        state_q;
    logic [31:0]   pc_q;
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          drop_q;
    logic          mem_req_q, launch_q;
    logic [31:0]   mem_addr_q, if_ins_q, if_ins_pc_q;

    logic [31:0]   iq_ins_q [IQ_DEPTH];
    logic [31:0]   iq_pc_q  [IQ_DEPTH];

    logic          push, pop;
    logic [6:0]    opcode;
    logic [31:0]   jal_imm;

    assign opcode  = mem_data[6:0];
    assign jal_imm = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12],
                      mem_data[20], mem_data[30:21], 1'b0};

    // A flush squashes both the incoming word and any launch in the same cycle.
    assign push = rdy && !rob_flush && (state_q == WAIT_MEM) && mem_ready && !drop_q;
    assign pop  = rdy && !rob_flush && (count_q != '0) && !rob_full && !launch_q;

    always_ff @(posedge clk) begin
        if (push) begin
            iq_ins_q[tail_q] <= mem_data;
            iq_pc_q[tail_q]  <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            launch_q    <= 1'b0;
            if_ins_q    <= '0;
            if_ins_pc_q <= '0;
        end else if (rdy) begin
            if (rob_flush) begin
                head_q   <= '0;
                tail_q   <= '0;
                count_q  <= '0;
                launch_q <= 1'b0;
                pc_q     <= flush_pc;
                // An outstanding request keeps its handshake; only its data is discarded.
                if (state_q == WAIT_MEM && !mem_ready) begin
                    drop_q <= 1'b1;
                end else begin
                    drop_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            end else begin
                launch_q <= pop;
                if (pop) begin
                    if_ins_q    <= iq_ins_q[head_q];
                    if_ins_pc_q <= iq_pc_q[head_q];
                    head_q      <= head_q + AW'(1);
                end
                if (push) begin
                    tail_q <= tail_q + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase

                case (state_q)
                    IDLE: begin
                        if (count_q < CW'(IQ_DEPTH)) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc_q & ~32'h3;
                            state_q    <= WAIT_MEM;
                        end
                    end
                    WAIT_MEM: begin
                        if (mem_ready) begin
                            mem_req_q <= 1'b0;
                            state_q   <= IDLE;
                            if (drop_q) begin
                                drop_q <= 1'b0;
                            end else if (opcode == OP_JAL) begin
                                pc_q <= pc_q + jal_imm;
                            end else if (opcode == OP_JALR) begin
                                state_q <= STALL_JALR;
                            end else if (opcode == OP_BRANCH) begin
                                pc_q <= pc_q + 32'd4;
                            end else begin
                                pc_q <= pc_q + 32'd4;
                            end
                        end
                    end
                    STALL_JALR: begin
                        if (jalr_resolve) begin
                            pc_q    <= jalr_target & ~32'h1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_req            = mem_req_q;
    assign mem_addr           = mem_addr_q;
    assign if_ins_launch_flag = launch_q;
    assign if_ins             = if_ins_q;
    assign if_ins_pc          = if_ins_pc_q;
endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: a behavioural memory answers fetches
// and a monitor records requests and launches for the checks below.
module tb_instruction_fetcher;
    localparam int IQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, rdy, mem_ready, rob_full, rob_flush, jalr_resolve;
    logic        mem_req, flag;
    logic [31:0] mem_addr, mem_data, if_ins, if_ins_pc, flush_pc, jalr_target;

    always #5 clk = ~clk;

    instruction_fetcher #(.IQ_DEPTH(IQ_DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .rob_full(rob_full), .if_ins_launch_flag(flag), .if_ins(if_ins), .if_ins_pc(if_ins_pc),
        .rob_flush(rob_flush), .flush_pc(flush_pc),
        .jalr_resolve(jalr_resolve), .jalr_target(jalr_target)
    );

    logic [31:0] imem [256];
    bit          mem_en;
    int          mem_lat;
    logic [31:0] lpc[$], lins[$], rq[$];
    int          ready_cyc[$], launch_cyc[$];
    int          cyc = 0, vectors = 0, miscompares = 0;
    logic        prev_flag = 1'b0, prev_req = 1'b0;

    localparam logic [31:0] JAL_W    = 32'h020000EF;  // jal x1, +0x20
    localparam logic [31:0] BEQ_W    = 32'h00000463;  // beq x0, x0, +8
    localparam logic [31:0] JALR_W   = 32'h00008067;  // jalr x0, 0(x1)

    function automatic logic [31:0] addi_w(input int unsigned a);
        logic [31:0] t;
        t = a;
        return {t[11:0], 20'h00093};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mem_server();
        int lat = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req && mem_en) begin
                lat++;
                if (lat >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_data  = imem[mem_addr[9:2]];
                    lat = 0;
                end
            end else begin
                lat = 0;
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_ready) ready_cyc.push_back(cyc);
            if (mem_req && !prev_req) rq.push_back(mem_addr);
            if (flag) begin
                check("pulse_gap", 32'(prev_flag), 32'h0);
                lpc.push_back(if_ins_pc);
                lins.push_back(if_ins);
                launch_cyc.push_back(cyc);
            end
            prev_flag = flag;
            prev_req  = mem_req;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; rob_full = 1'b0; rob_flush = 1'b0;
        jalr_resolve = 1'b0; flush_pc = '0; jalr_target = '0;
        mem_en = 1'b1; mem_lat = 3;
        for (int i = 0; i < 256; i++) imem[i] = addi_w(i * 4);
        repeat (3) tick();
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_flag", 32'(flag), 32'h0);
        check("rst_if_ins", if_ins, 32'h0);
        check("rst_if_ins_pc", if_ins_pc, 32'h0);
        lpc.delete(); lins.delete(); rq.delete();
        ready_cyc.delete(); launch_cyc.delete();
        rst = 1'b0;
    endtask

    task automatic wait_lq(input int n, input string tag);
        int k = 0;
        while (lpc.size() < n && k < 400) begin tick(); k++; end
        check(tag, 32'(lpc.size() >= n), 32'h1);
    endtask

    task automatic wait_rq(input int n, input string tag);
        int k = 0;
        while (rq.size() < n && k < 400) begin tick(); k++; end
        check(tag, 32'(rq.size() >= n), 32'h1);
    endtask

    task automatic wait_addr(input logic [31:0] a, input string tag);
        int k = 0;
        while (!(mem_req && mem_addr == a) && k < 400) begin tick(); k++; end
        check(tag, mem_addr, a);
    endtask

    initial begin
        logic [31:0] exp_pc [7];
        int l0, r0, hits;
        mem_ready = 1'b0; mem_data = '0;
        fork
            mem_server();
            monitor();
        join_none

        // Straight-line code, a JAL at 0x10 and a not-taken branch at 0x30.
        do_reset();
        imem[32'h10 >> 2] = JAL_W;
        imem[32'h30 >> 2] = BEQ_W;
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h30, 32'h34};
        wait_lq(7, "a_launch_count");
        for (int i = 0; i < 7; i++) begin
            check($sformatf("a_pc%0d", i), lpc[i], exp_pc[i]);
            check($sformatf("a_req%0d", i), rq[i], exp_pc[i]);
        end
        check("a_ins0", lins[0], addi_w(0));
        check("a_ins3", lins[3], addi_w(12));
        check("a_ins_jal", lins[4], JAL_W);
        check("a_ins_beq", lins[5], BEQ_W);
        check("a_latency", 32'(launch_cyc[0] - ready_cyc[0]), 32'd1);

        // JALR stall; a resolve pulse while rdy is low must be ignored.
        do_reset();
        imem[32'h8 >> 2] = JALR_W;
        wait_lq(3, "b_launch_count");
        repeat (30) tick();
        check("b_req_count_stall", 32'(rq.size()), 32'd3);
        check("b_mem_req_stall", 32'(mem_req), 32'h0);
        check("b_jalr_ins", lins[2], JALR_W);
        check("b_jalr_pc", lpc[2], 32'h8);
        rdy = 1'b0; jalr_resolve = 1'b1; jalr_target = 32'h81;
        tick();
        rdy = 1'b1; jalr_resolve = 1'b0;
        repeat (10) tick();
        check("b_rdy_freeze", 32'(rq.size()), 32'd3);
        jalr_resolve = 1'b1; jalr_target = 32'h41;
        tick();
        jalr_resolve = 1'b0;
        wait_rq(4, "b_req_after_resolve");
        check("b_target_addr", rq[3], 32'h40);
        wait_lq(4, "b_launch_after_resolve");
        check("b_target_pc", lpc[3], 32'h40);

        // Back-pressure: queue fills, fetching stops, then drains in order.
        do_reset();
        rob_full = 1'b1;
        repeat (40) tick();
        check("c_no_launch", 32'(lpc.size()), 32'd0);
        check("c_req_count", 32'(rq.size()), 32'(IQ_DEPTH));
        check("c_mem_req_off", 32'(mem_req), 32'h0);
        rob_full = 1'b0;
        wait_lq(IQ_DEPTH, "c_drain_count");
        for (int i = 0; i < IQ_DEPTH; i++)
            check($sformatf("c_pc%0d", i), lpc[i], 32'(i * 4));

        // Flush while the fetch of 0x20 is outstanding.
        do_reset();
        wait_addr(32'h20, "d_reach_0x20");
        mem_en = 1'b0;
        rob_flush = 1'b1; flush_pc = 32'h100;
        tick();
        rob_flush = 1'b0;
        l0 = lpc.size(); r0 = rq.size();
        check("d_req_held", 32'(mem_req), 32'h1);
        check("d_addr_held", mem_addr, 32'h20);
        mem_en = 1'b1;
        wait_rq(r0 + 1, "d_req_after_flush");
        check("d_flush_addr", rq[r0], 32'h100);
        wait_lq(l0 + 1, "d_launch_after_flush");
        check("d_flush_pc", lpc[l0], 32'h100);
        hits = 0;
        foreach (lpc[i]) if (lpc[i] == 32'h20) hits++;
        check("d_0x20_dropped", 32'(hits), 32'd0);

        // Flush coinciding with mem_ready and a pending launch.
        do_reset();
        rob_full = 1'b1;
        wait_addr(32'hC, "e_reach_0xC");
        mem_en = 1'b0;
        tick();
        mem_en = 1'b1; mem_lat = 1; rob_full = 1'b0;
        rob_flush = 1'b1; flush_pc = 32'h200;
        tick();
        rob_flush = 1'b0; mem_lat = 3;
        check("e_no_launch", 32'(flag), 32'h0);
        check("e_req_done", 32'(mem_req), 32'h0);
        wait_rq(5, "e_req_after_flush");
        check("e_flush_addr", rq[4], 32'h200);
        wait_lq(1, "e_launch_after_flush");
        check("e_first_pc", lpc[0], 32'h200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
